// File: rtl/npc_btb_unit.sv
// Next-PC unit: owns the IF PC, predicts with a direct-mapped BTB
// and 2-bit counters, and resolves jal (ID) / branch+jalr (EX) redirects.
module npc_btb_unit #(
  parameter int               XLEN        = 32,
  parameter int               BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0]  RESET_PC    = '0
) (
  input  logic            CPU_CLK,
  input  logic            CPU_RST_N,
  input  logic            StallF,
  output logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            JalD,
  input  logic [XLEN-1:0] JalTargetD,
  input  logic [XLEN-1:0] PCD,
  input  logic            PredTakenD,
  input  logic            BrE,
  input  logic            BrTakenE,
  input  logic            JalrE,
  input  logic [XLEN-1:0] BrTargetE,
  input  logic [XLEN-1:0] JalrTargetE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PredTargetE,
  input  logic            PredTakenE,
  output logic            RedirectD,
  output logic            RedirectE
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = XLEN - IDX - 2;

  typedef enum logic [1:0] {
    T_BR   = 2'd0,
    T_JAL  = 2'd1,
    T_JALR = 2'd2
  } btb_type_e;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TW-1:0]          tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
  btb_type_e              typ_q [BTB_ENTRIES];
  logic [1:0]             ctr_q [BTB_ENTRIES];

  logic [XLEN-1:0] pcf_q, pcf_d;

  logic [IDX-1:0] idx_f, idx_e, idx_d;
  logic           hit_f, hit_e, hit_d;

  logic            br_mis, jalr_mis;
  logic [XLEN-1:0] corr_pc;

  logic            w_en;
  logic [IDX-1:0]  w_idx;
  logic [TW-1:0]   w_tag;
  logic [XLEN-1:0] w_tgt;
  btb_type_e       w_typ;
  logic [1:0]      w_ctr;

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{PCD[1:0]};

  assign idx_f = pcf_q[IDX+1:2];
  assign idx_e = PCE[IDX+1:2];
  assign idx_d = PCD[IDX+1:2];

  assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == pcf_q[XLEN-1:IDX+2]);
  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == PCE[XLEN-1:IDX+2]);
  assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == PCD[XLEN-1:IDX+2]);

  assign PCF         = pcf_q;
  assign PredTakenF  = hit_f && (typ_q[idx_f] != T_BR || ctr_q[idx_f][1]);
  assign PredTargetF = tgt_q[idx_f];

  assign br_mis = BrE && ((BrTakenE != PredTakenE) ||
                  (BrTakenE && PredTargetE != BrTargetE));
  assign jalr_mis = JalrE && (!PredTakenE || PredTargetE != JalrTargetE);

  assign RedirectE = br_mis || jalr_mis;
  assign RedirectD = JalD && !PredTakenD && !RedirectE && !StallF;

  always_comb begin
    corr_pc = PCE + XLEN'(4);
    if (JalrE)         corr_pc = JalrTargetE;
    else if (BrTakenE) corr_pc = BrTargetE;
  end

  always_comb begin
    pcf_d = pcf_q + XLEN'(4);
    if (RedirectE)       pcf_d = corr_pc;
    else if (RedirectD)  pcf_d = JalTargetD;
    else if (StallF)     pcf_d = pcf_q;
    else if (PredTakenF) pcf_d = PredTargetF;
  end

  // Single write port: EX updates always pre-empt an ID jal allocation.
  always_comb begin
    w_en  = 1'b0;
    w_idx = idx_e;
    w_tag = PCE[XLEN-1:IDX+2];
    w_tgt = JalrTargetE;
    w_typ = T_BR;
    w_ctr = 2'b00;
    if (JalrE) begin
      w_en  = 1'b1;
      w_typ = T_JALR;
      w_ctr = 2'b11;
    end else if (BrE && hit_e) begin
      w_en  = 1'b1;
      w_tgt = BrTakenE ? BrTargetE : tgt_q[idx_e];
      w_ctr = ctr_q[idx_e];
      if (BrTakenE && ctr_q[idx_e] != 2'b11)
        w_ctr = ctr_q[idx_e] + 2'b01;
      else if (!BrTakenE && ctr_q[idx_e] != 2'b00)
        w_ctr = ctr_q[idx_e] - 2'b01;
    end else if (BrE && BrTakenE) begin
      w_en  = 1'b1;
      w_tgt = BrTargetE;
      w_ctr = 2'b10;
    end else if (JalD && !StallF && !hit_d) begin
      w_en  = 1'b1;
      w_idx = idx_d;
      w_tag = PCD[XLEN-1:IDX+2];
      w_tgt = JalTargetD;
      w_typ = T_JAL;
      w_ctr = 2'b11;
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      pcf_q   <= RESET_PC;
      valid_q <= '0;
    end else begin
      pcf_q <= pcf_d;
      if (w_en) valid_q[w_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge CPU_CLK) begin
    if (w_en) begin
      tag_q[w_idx] <= w_tag;
      tgt_q[w_idx] <= w_tgt;
      typ_q[w_idx] <= w_typ;
      ctr_q[w_idx] <= w_ctr;
    end
  end

endmodule

// File: doc/npc_btb_unit.md
# npc_btb_unit

Parametrised next-PC unit for the RV32 pipeline that owns the IF-stage PC register, predicts control flow with a direct-mapped branch target buffer (BTB) and 2-bit counters, and resolves redirects from ID (jal) and EX (branch/jalr). It replaces the purely combinational next-PC mux: prediction happens in IF, and mispredictions are detected and corrected in ID/EX with flush requests to the hazard unit.

## Interface
- XLEN, 32, datapath/PC width
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX = log2(BTB_ENTRIES)
- RESET_PC, 32'h0000_0000, PCF value after reset

Ports:
- CPU_CLK  in  1  clock, rising edge
- CPU_RST_N  in  1  asynchronous, active-low reset
- StallF  in  1  hold PCF (IF stall)
- PCF  out  XLEN  current fetch PC (registered)
- PredTakenF  out  1  BTB predicts taken for PCF (combinational)
- PredTargetF  out  XLEN  predicted target for PCF (valid when PredTakenF)
- JalD  in  1  jal in ID
- JalTargetD, PCD  in  XLEN  jal target / PC of ID instruction
- PredTakenD  in  1  prediction carried with ID instruction
- BrE, BrTakenE, JalrE  in  1  branch in EX / branch outcome / jalr in EX
- BrTargetE, JalrTargetE, PCE, PredTargetE  in  XLEN  EX targets, EX PC, carried prediction target
- PredTakenE  in  1  prediction carried with EX instruction
- RedirectD  out  1  ID redirect: flush IF/ID
- RedirectE  out  1  EX redirect: flush IF/ID and ID/EX

## Operation
- BTB entry: valid, tag = PC[XLEN-1:IDX+2], target[XLEN-1:0], type (BR/JAL/JALR), ctr[1:0]. Index = PC[IDX+1:2].
- Lookup (comb, on PCF): hit = valid && tag match. PredTakenF = hit && (type≠BR || ctr[1]). PredTargetF = entry target.
- EX mispredict:
  - BrE: BrTakenE≠PredTakenE, or BrTakenE && PredTargetE≠BrTargetE. Correct PC = BrTakenE ? BrTargetE : PCE+4.
  - JalrE: !PredTakenE or PredTargetE≠JalrTargetE. Correct PC = JalrTargetE.
  - BrE and JalrE are never asserted together.
- ID redirect: RedirectD = JalD && !PredTakenD && !RedirectE && !StallF. Target = JalTargetD.
- Next PC priority: RedirectE correct PC > RedirectD JalTargetD > StallF (hold) > PredTakenF ? PredTargetF : PCF+4. RedirectE loads even when StallF=1.
- BTB update, one write port, at clock edge:
  - EX, BrE hit on PCE: ctr saturating ±1 by BrTakenE; target := BrTargetE when taken.
  - EX, BrE miss and taken: allocate BR, ctr=2'b10.
  - EX, BrE miss and not taken: no write.
  - EX, JalrE: write/overwrite JALR, target := JalrTargetE, ctr=2'b11.
  - ID, JalD && !StallF && miss on PCD: allocate JAL, target := JalTargetD, ctr=2'b11.
  - Same-cycle EX and ID writes: EX wins, the ID write is dropped regardless of index.
  - Allocation overwrites the existing entry (direct-mapped, no victim logic).
- BrE/JalrE/JalD are asserted for exactly one cycle per instruction (hazard unit guarantees). The counter update therefore needs no stall qualifier.
- Arithmetic: PC+4 and PCE+4 wrap modulo 2^XLEN. Targets are used as given, with no alignment check.

## Timing
- Reset (async assert, sync deassert by the system): PCF=RESET_PC, all valid=0. PredTakenF=0 and RedirectD/E=0 while inputs are idle.
- First rising edge after reset release: PCF=RESET_PC+4 unless a BTB hit is predicted (impossible immediately after reset) or a redirect is active.
- RedirectD/RedirectE are combinational in the same cycle as the causing inputs. PCF takes the new value at the next edge.
- Redirect penalty: 1 bubble for jal miss, 2 bubbles for EX mispredict, 0 for a correct prediction.
- BTB write becomes visible to lookup on the cycle after the edge. There is no write-to-read bypass.
- Reset asserted mid-operation: PCF and valid bits clear immediately. Targets and counters need not be cleared.

## Test plan
- Reset and sequential fetch: release reset with RESET_PC=0 and no control inputs -> PCF 0,4,8,12 on successive edges; PredTakenF=0.
- Taken branch, learning: branch at 0x10 with BrTakenE=1, BrTargetE=0x40, PredTakenE=0 -> RedirectE=1, next PCF=0x40. Next fetch of 0x10 -> PredTakenF=1, PredTargetF=0x40. Resolve taken with PredTakenE=1, PredTargetE=0x40 -> no redirect; ctr goes 2→3.
- Counter hysteresis: same branch at ctr=3 resolves not-taken twice -> ctr 3→2 (still predicts taken, RedirectE to 0x14) then 2→1 -> PredTakenF=0 on the next fetch of 0x10.
- jal in ID: JalD=1, PCD=0x20, JalTargetD=0x100, PredTakenD=0 -> RedirectD=1, PCF=0x100. Refetch of 0x20 -> PredTakenF=1, target 0x100. Same jal with StallF=1 -> RedirectD=0 and PCF held.
- Priority and collision: RedirectE (jalr to 0x200) with JalD=1 and StallF=1 in the same cycle -> RedirectE=1, RedirectD=0, PCF=0x200; only the JALR BTB entry is written.
- Wrap and aliasing: PCF=32'hFFFF_FFFC, no hit -> next PCF=0. Two branches with the same index but different tags -> the second allocation evicts the first, and the first then misses.
